// File: rtl/sc_button_debouncer.sv
// Three-channel push-button conditioner: 2-FF synchroniser, per-channel debounce FSM,
// registered active-low levels and a one-cycle active-low strobe on each accepted press.
module sc_button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic       SC_BUTTONDEBOUNCER_CLOCK_50,
  input  logic       SC_BUTTONDEBOUNCER_RESET_InHigh,
  input  logic       SC_BUTTONDEBOUNCER_startRaw_InLow,
  input  logic       SC_BUTTONDEBOUNCER_leftRaw_InLow,
  input  logic       SC_BUTTONDEBOUNCER_rightRaw_InLow,
  output logic       SC_BUTTONDEBOUNCER_start_OutLow,
  output logic       SC_BUTTONDEBOUNCER_left_OutLow,
  output logic       SC_BUTTONDEBOUNCER_right_OutLow,
  output logic [2:0] SC_BUTTONDEBOUNCER_pressStrobe_OutLow
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } debounceState_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  generate
    if ((DEBOUNCE_CYCLES < 2) || (64'(DEBOUNCE_CYCLES) > (64'd1 << CNT_WIDTH))) begin : gBadParams
      $error("sc_button_debouncer: DEBOUNCE_CYCLES must lie in 2..2**CNT_WIDTH");
    end
  endgenerate

  logic [2:0] rawKeys;
  logic [2:0] levelKeys;
  logic [2:0] strobeKeys;

  assign rawKeys = {SC_BUTTONDEBOUNCER_rightRaw_InLow,
                    SC_BUTTONDEBOUNCER_leftRaw_InLow,
                    SC_BUTTONDEBOUNCER_startRaw_InLow};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gChannel
      logic                 sync1Reg;
      logic                 sync2Reg;
      logic                 outReg;
      logic                 pressEventReg;
      logic                 strobeReg;
      logic [CNT_WIDTH-1:0] countReg;
      debounceState_t       stateReg;

      always_ff @(posedge SC_BUTTONDEBOUNCER_CLOCK_50) begin
        if (SC_BUTTONDEBOUNCER_RESET_InHigh) begin
          sync1Reg      <= 1'b1;
          sync2Reg      <= 1'b1;
          outReg        <= 1'b1;
          pressEventReg <= 1'b0;
          strobeReg     <= 1'b1;
          countReg      <= '0;
          stateReg      <= STABLE;
        end else begin
          sync1Reg      <= rawKeys[gi];
          sync2Reg      <= sync1Reg;
          pressEventReg <= 1'b0;
          // Strobe trails the level update by one cycle.
          strobeReg     <= ~pressEventReg;
          case (stateReg)
            STABLE: begin
              countReg <= '0;
              if (sync2Reg != outReg) stateReg <= PENDING;
            end
            PENDING: begin
              if (sync2Reg == outReg) begin
                countReg <= '0;
                stateReg <= STABLE;
              end else if (countReg == CNT_LAST) begin
                outReg        <= sync2Reg;
                pressEventReg <= ~sync2Reg;
                countReg      <= '0;
                stateReg      <= STABLE;
              end else begin
                countReg <= countReg + CNT_ONE;
              end
            end
            default: begin
              countReg <= '0;
              stateReg <= STABLE;
            end
          endcase
        end
      end

      assign levelKeys[gi]  = outReg;
      assign strobeKeys[gi] = strobeReg;
    end
  endgenerate

  assign SC_BUTTONDEBOUNCER_start_OutLow       = levelKeys[0];
  assign SC_BUTTONDEBOUNCER_left_OutLow        = levelKeys[1];
  assign SC_BUTTONDEBOUNCER_right_OutLow       = levelKeys[2];
  assign SC_BUTTONDEBOUNCER_pressStrobe_OutLow = strobeKeys;

endmodule

// File: tb/tb_sc_button_debouncer.sv
// Bench for sc_button_debouncer: directed key scenarios plus random bouncing keys,
// checked cycle by cycle against a sample-window reference model through a scoreboard queue.
module tb_sc_button_debouncer;

  localparam int D    = 4;
  localparam int HMAX = 8192;

  logic       clk;
  logic       resetIn;
  logic [2:0] rawIn;
  logic       startLevel, leftLevel, rightLevel;
  logic [2:0] strobeOut;

  sc_button_debouncer #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(19)) dut (
    .SC_BUTTONDEBOUNCER_CLOCK_50          (clk),
    .SC_BUTTONDEBOUNCER_RESET_InHigh      (resetIn),
    .SC_BUTTONDEBOUNCER_startRaw_InLow    (rawIn[0]),
    .SC_BUTTONDEBOUNCER_leftRaw_InLow     (rawIn[1]),
    .SC_BUTTONDEBOUNCER_rightRaw_InLow    (rawIn[2]),
    .SC_BUTTONDEBOUNCER_start_OutLow      (startLevel),
    .SC_BUTTONDEBOUNCER_left_OutLow       (leftLevel),
    .SC_BUTTONDEBOUNCER_right_OutLow      (rightLevel),
    .SC_BUTTONDEBOUNCER_pressStrobe_OutLow(strobeOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: hist[e] is the raw value captured at edge e (1s across reset).
  // A level flips at edge e when the synchronised samples seen on the last D+1 edges
  // (hist[e-2-D] .. hist[e-2]) all differ from it; a press strobes on the following edge.
  logic [2:0] hist [0:HMAX-1];
  int         edgeIdx;
  logic [2:0] levelM;
  logic [2:0] strobeM;
  logic [2:0] pressEvtM;
  logic [5:0] expQ [$];

  int errors = 0;
  int checks = 0;
  int cycleNo = 0;

  task automatic modelEdge(input logic rst, input logic [2:0] raw);
    logic accept;
    if (rst) begin
      hist[edgeIdx]     = 3'b111;
      hist[edgeIdx - 1] = 3'b111;
      levelM    = 3'b111;
      strobeM   = 3'b111;
      pressEvtM = 3'b000;
    end else begin
      hist[edgeIdx] = raw;
      strobeM   = ~pressEvtM;
      pressEvtM = 3'b000;
      for (int c = 0; c < 3; c++) begin
        accept = 1'b1;
        for (int k = 0; k <= D; k++)
          if (hist[edgeIdx - 2 - k][c] == levelM[c]) accept = 1'b0;
        if (accept) begin
          levelM[c] = ~levelM[c];
          if (levelM[c] == 1'b0) pressEvtM[c] = 1'b1;
        end
      end
    end
    edgeIdx++;
    expQ.push_back({levelM, strobeM});
  endtask

  task automatic step(input logic rst, input logic [2:0] raw);
    @(negedge clk);
    resetIn = rst;
    rawIn   = raw;
    if (edgeIdx < HMAX - 1) modelEdge(rst, raw);
  endtask

  task automatic hold(input int n, input logic rst, input logic [2:0] raw);
    for (int i = 0; i < n; i++) step(rst, raw);
  endtask

  // Monitor: outputs are valid every cycle once the model starts predicting.
  initial begin : monitor
    logic [5:0] exp;
    forever begin
      @(posedge clk);
      #1;
      cycleNo++;
      if (expQ.size() > 0) begin
        exp = expQ.pop_front();
        checks++;
        if ({rightLevel, leftLevel, startLevel} !== exp[5:3]) begin
          errors++;
          $display("FAIL level cycle=%0d got=%b want=%b", cycleNo,
                   {rightLevel, leftLevel, startLevel}, exp[5:3]);
        end
        checks++;
        if (strobeOut !== exp[2:0]) begin
          errors++;
          $display("FAIL strobe cycle=%0d got=%b want=%b", cycleNo, strobeOut, exp[2:0]);
        end
        $display("cycle=%0d rst=%b raw=%b level=%b strobe=%b", cycleNo, resetIn, rawIn,
                 {rightLevel, leftLevel, startLevel}, strobeOut);
      end
    end
  end

  initial begin : driver
    int remain [3];
    logic [2:0] rawR;
    for (int i = 0; i < HMAX; i++) hist[i] = 3'b111;
    edgeIdx   = D + 3;
    levelM    = 3'b111;
    strobeM   = 3'b111;
    pressEvtM = 3'b000;
    resetIn   = 1'b1;
    rawIn     = 3'b000;

    hold(3, 1'b1, 3'b000);                 // reset with all keys pressed
    hold(8, 1'b0, 3'b111);
    hold(10, 1'b0, 3'b110);                // clean start press
    hold(10, 1'b0, 3'b111);                // release
    hold(3, 1'b0, 3'b101);                 // bouncing left
    hold(1, 1'b0, 3'b111);
    hold(10, 1'b0, 3'b101);
    hold(10, 1'b0, 3'b111);
    hold(4, 1'b0, 3'b011);                 // right glitch of D cycles
    hold(10, 1'b0, 3'b111);
    hold(5, 1'b0, 3'b011);                 // right pulse of D+1 cycles, just accepted
    hold(10, 1'b0, 3'b111);
    hold(10, 1'b0, 3'b001);                // simultaneous left+right
    hold(10, 1'b0, 3'b111);
    hold(5, 1'b0, 3'b001);                 // reset mid-count, keys held
    hold(1, 1'b1, 3'b001);
    hold(10, 1'b0, 3'b001);
    hold(10, 1'b0, 3'b111);

    rawR = 3'b111;
    for (int c = 0; c < 3; c++) remain[c] = 1;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < 3; c++) begin
        remain[c]--;
        if (remain[c] <= 0) begin
          rawR[c]   = ~rawR[c];
          remain[c] = int'($urandom_range(1, D + 5));
        end
      end
      step(($urandom_range(0, 79) == 0), rawR);
    end
    hold(12, 1'b0, 3'b111);

    for (int i = 0; i < 5 && expQ.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
